// File: rtl/bp_pkg.sv
// Shared branch-predictor types and helpers, common to the predictor table
// and the resolve queue.
package bp_pkg;

    localparam int BP_IDX_W = 4;

    typedef struct packed {
        logic                taken;
        logic [BP_IDX_W-1:0] idx;
    } bp_entry_t;

    // Width needed to hold an entry count from 0 up to and including depth.
    function automatic int bp_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bp_resolve_queue_if.sv
// Fetch/execute-side handshake and predictor-training bus of the resolve queue.
interface bp_resolve_queue_if #(
    parameter int IDX_W = bp_pkg::BP_IDX_W
);
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             res_ready;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             mispredict;

    modport master (
        output pred_valid, pred_taken, pred_idx, res_valid, res_taken,
        input  pred_ready, res_ready, upd_valid, upd_idx, upd_taken, mispredict
    );

    modport slave (
        input  pred_valid, pred_taken, pred_idx, res_valid, res_taken,
        output pred_ready, res_ready, upd_valid, upd_idx, upd_taken, mispredict
    );

endinterface

// File: rtl/bp_fifo.sv
// Circular in-order storage with head/tail/count and a single-cycle flush.
// No full-bypass: a push is refused at full even if a pop happens alongside.
module bp_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5,
    localparam int OCC_W = bp_cnt_w(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [OCC_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == OCC_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_head];

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bp_resolve_queue.sv
// Tracks predicted branches in order, trains the predictor at resolve, raises
// a flush pulse on mispredict and keeps saturating branch/miss statistics.
module bp_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = BP_IDX_W,
    parameter int CNT_W = 16,
    localparam int OCC_W = bp_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    bp_resolve_queue_if.slave bus,
    output logic [OCC_W-1:0]  o_occupancy,
    output logic [CNT_W-1:0]  o_branch_cnt,
    output logic [CNT_W-1:0]  o_miss_cnt
);

    logic [IDX_W:0]   w_rdata;
    logic             w_head_taken;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_miss;
    logic             w_push;

    logic             r_upd_valid;
    logic [IDX_W-1:0] r_upd_idx;
    logic             r_upd_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    assign w_head_taken = w_rdata[IDX_W];
    assign w_head_idx   = w_rdata[IDX_W-1:0];

    assign w_pop  = bus.res_valid && !w_empty;
    assign w_miss = w_pop && (w_head_taken != bus.res_taken);
    // A prediction arriving alongside a mispredict is on the wrong path.
    assign w_push = bus.pred_valid && !w_full && !w_miss;

    bp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_miss),
        .i_wdata ({bus.pred_taken, bus.pred_idx}),
        .o_rdata (w_rdata),
        .o_count (o_occupancy),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_valid  <= 1'b0;
            r_upd_idx    <= '0;
            r_upd_taken  <= 1'b0;
            r_mispredict <= 1'b0;
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_upd_valid  <= w_pop;
            r_mispredict <= w_miss;
            if (w_pop) begin
                r_upd_idx   <= w_head_idx;
                r_upd_taken <= bus.res_taken;
            end
            if (w_pop && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign bus.pred_ready = !w_full;
    assign bus.res_ready  = !w_empty;
    assign bus.upd_valid  = r_upd_valid;
    assign bus.upd_idx    = r_upd_idx;
    assign bus.upd_taken  = r_upd_taken;
    assign bus.mispredict = r_mispredict;
    assign o_branch_cnt   = r_branch_cnt;
    assign o_miss_cnt     = r_miss_cnt;

endmodule
